div_unit: RTL and testbench

- Multi-cycle iterative integer divider for the M-extension divide/remainder ops (div, divu, rem, remu).
- Sits directly downstream of the ALU decoder: consumes its 5-bit aluControl and register operands.
- Returns the result under a start/busy/done handshake, so the datapath can stall while the main ALU stays single-cycle.
- Radix-2 restoring algorithm on magnitudes, with a sign fix-up step.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/div_step.sv | 20 ++
 rtl/div_unit.sv | 123 ++++++++++++
 tb/tb_div_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: aluControl encodings for the divide ops and the
// divider state type. The ALU decoder should use these same constants.
package alu_pkg;

  localparam logic [4:0] ALU_DIV  = 5'h0e;
  localparam logic [4:0] ALU_DIVU = 5'h0f;
  localparam logic [4:0] ALU_REM  = 5'h10;
  localparam logic [4:0] ALU_REMU = 5'h11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic logic is_div_op(input logic [4:0] ctl);
    return (ctl == ALU_DIV) || (ctl == ALU_DIVU) || (ctl == ALU_REM) || (ctl == ALU_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] ctl);
    return (ctl == ALU_DIV) || (ctl == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] ctl);
    return (ctl == ALU_REM) || (ctl == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         qbit_o
);

  logic [W:0] trial;

  assign trial  = {rem_i, bit_i};
  assign qbit_o = (trial >= {1'b0, divisor_i});
  // rem_i < divisor_i, so the true difference always fits in W bits.
  assign rem_o  = qbit_o ? (trial[W-1:0] - divisor_i) : trial[W-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for div/divu/rem/remu with start/busy/done
// handshake. Iterates on magnitudes, fixes signs in a final step.
module div_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      aluControl,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;
  logic            is_rem_q, neg_quo_q, neg_rem_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] dq_q;    // dividend bits shift out MSB-first, quotient bits shift in
  logic [XLEN-1:0] prem_q;
  logic [CW-1:0]   cnt_q;

  logic            op_signed, op_rem, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic [XLEN-1:0] prem_d;
  logic            qbit_d;

  assign op_signed = is_signed_op(aluControl);
  assign op_rem    = is_rem_op(aluControl);
  assign a_neg     = op_signed & srcA[XLEN-1];
  assign b_neg     = op_signed & srcB[XLEN-1];
  assign a_mag     = a_neg ? (~srcA + 1'b1) : srcA;
  assign b_mag     = b_neg ? (~srcB + 1'b1) : srcB;
  assign div_zero  = (srcB == '0);
  assign overflow  = op_signed && (srcA == INT_MIN) && (srcB == '1);
  // Overflow quotient equals the dividend (INT_MIN), so srcA serves both cases.
  assign special_res = div_zero ? (op_rem ? srcA : '1)
                                : (op_rem ? '0 : srcA);

  div_step #(.W(XLEN)) u_step (
    .rem_i     (prem_q),
    .bit_i     (dq_q[XLEN-1]),
    .divisor_i (divisor_q),
    .rem_o     (prem_d),
    .qbit_o    (qbit_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divisor_q <= '0;
      dq_q      <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && is_div_op(aluControl)) begin
            busy_q <= 1'b1;
            if (div_zero || overflow) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              is_rem_q  <= op_rem;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              divisor_q <= b_mag;
              dq_q      <= a_mag;
              prem_q    <= '0;
              cnt_q     <= CW'(XLEN - 1);
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          prem_q <= prem_d;
          dq_q   <= {dq_q[XLEN-2:0], qbit_d};
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (is_rem_q) begin
            result_q <= neg_rem_q ? (~prem_q + 1'b1) : prem_q;
          end else begin
            result_q <= neg_quo_q ? (~dq_q + 1'b1) : dq_q;
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_div_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  aluControl;
  logic [31:0] srcA, srcB;
  logic        busy, done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_result = '0;

  div_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .aluControl (aluControl),
    .srcA       (srcA),
    .srcB       (srcB),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_s = (op == ALU_DIV) || (op == ALU_REM);
    bit is_r = (op == ALU_REM) || (op == ALU_REMU);
    int sa = a;
    int sb = b;
    if (b == 0) return is_r ? a : 32'hFFFF_FFFF;
    if (is_s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_r ? 32'h0 : 32'h8000_0000;
      return is_r ? (sa % sb) : (sa / sb);
    end
    return is_r ? (a % b) : (a / b);
  endfunction

  function automatic int model_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_s = (op == ALU_DIV) || (op == ALU_REM);
    if (b == 0) return 1;
    if (is_s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Accept on the next edge (cycle 0), observe cycles 1..latency+1.
  // Extra starts are injected in cycles poke1/poke2 to exercise busy handling.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke1, input int poke2);
    logic [31:0] exp_res = model(op, a, b);
    int          exp_lat = model_latency(op, a, b);
    int          n_done  = 0;
    int          done_c  = -1;
    logic [31:0] got     = '0;
    start = 1'b1; aluControl = op; srcA = a; srcB = b;
    tick();
    start = 1'b0; srcA = $urandom; srcB = $urandom;
    for (int c = 1; c <= exp_lat; c++) begin
      if (c == 1) begin
        check_eq("busy_c1", 32'(busy), 32'd1);
        if (!done) check_eq("result_hold", result, last_result);
      end
      if (done) begin
        n_done++;
        done_c = c;
        got = result;
      end
      if (c == poke1 || c == poke2) begin
        start = 1'b1; aluControl = ALU_DIVU; srcA = $urandom; srcB = $urandom_range(1, 50);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check_eq("done_pulses", 32'(n_done), 32'd1);
    check_eq("done_cycle", 32'(done_c), 32'(exp_lat));
    check_eq("result", got, exp_res);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("done_after", 32'(done), 32'd0);
    check_eq("result_held", result, exp_res);
    $display("op=%02h a=%08h b=%08h -> result=%08h expected=%08h done_cycle=%0d",
             op, a, b, got, exp_res, done_c);
    last_result = exp_res;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0] ops [4];
    int         n_done;
    ops[0] = ALU_DIV; ops[1] = ALU_DIVU; ops[2] = ALU_REM; ops[3] = ALU_REMU;

    rst_n = 1'b0; start = 1'b0; aluControl = '0; srcA = '0; srcB = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_result", result, 32'd0);

    // Directed cases
    run_op(ALU_DIV,  32'hFFFF_FFF9, 32'd2,  -1, -1);
    run_op(ALU_REM,  32'hFFFF_FFF9, 32'd2,  -1, -1);
    run_op(ALU_DIVU, 32'hFFFF_FFFF, 32'h10, -1, -1);
    run_op(ALU_REMU, 32'hFFFF_FFFF, 32'h10, -1, -1);
    run_op(ALU_DIV,  32'd5, 32'd0, -1, -1);
    run_op(ALU_REMU, 32'd5, 32'd0, -1, -1);
    run_op(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, -1, -1);

    // Starts while busy are ignored; next op is back-to-back in cycle 35
    run_op(ALU_DIVU, 32'd100, 32'd7, 5, 20);
    run_op(ALU_REM,  32'h8000_0000, 32'd3, -1, -1);

    // Start with a non-divide aluControl is ignored
    start = 1'b1; aluControl = 5'h03; srcA = 32'd9; srcB = 32'd3;
    tick();
    start = 1'b0;
    check_eq("badop_busy", 32'(busy), 32'd0);
    tick();
    check_eq("badop_busy2", 32'(busy), 32'd0);
    check_eq("badop_done", 32'(done), 32'd0);

    // Abort a running div with reset at cycle 10
    start = 1'b1; aluControl = ALU_DIV; srcA = 32'd1000; srcB = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_result", result, 32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n_done++;
      tick();
    end
    check_eq("abort_no_done", 32'(n_done), 32'd0);
    last_result = '0;
    run_op(ALU_DIV, 32'd1000, 32'hFFFF_FFF9, -1, -1);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      run_op(ops[$urandom_range(0, 3)], pick_operand(), pick_operand(), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
